// File: rtl/pong_pkg.sv
// Shared pong definitions: paddle direction encoding and controls-bus bit positions.
// Also used by the paddle mover, so changes here ripple into both blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam int CTRL_UP = 1;
    localparam int CTRL_DN = 0;

    function automatic logic [1:0] dir_to_ctrl(input dir_t d);
        logic [1:0] c;
        c          = 2'b00;
        c[CTRL_UP] = (d == DIR_UP);
        c[CTRL_DN] = (d == DIR_DOWN);
        return c;
    endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// Button/tick inputs and step/debug outputs of one player's paddle input front end.
// The master side is the board/game logic, the slave side is paddle_input_ctrl.
interface paddle_input_ctrl_if;

    logic       tick;
    logic       btn_up_raw;
    logic       btn_dn_raw;
    logic [1:0] controls;
    logic [1:0] pressed;

    modport master (
        output tick,
        output btn_up_raw,
        output btn_dn_raw,
        input  controls,
        input  pressed
    );

    modport slave (
        input  tick,
        input  btn_up_raw,
        input  btn_dn_raw,
        output controls,
        output pressed
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability filter for one asynchronous button.
// Raw-to-output latency is 2 + DEBOUNCE_CYCLES clocks; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // any cycle agreeing with the accepted level restarts the count
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Debounced up/down buttons to one-tick paddle step pulses with hold-to-repeat.
// Steps appear only in tick cycles (combinational from registered state); no backpressure.
module paddle_input_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 4,
    parameter int REPEAT_PERIOD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    paddle_input_ctrl_if.slave  bus
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic          w_up;
    logic          w_dn;
    dir_t          w_dir;
    logic          w_press;
    logic          w_tzero;
    logic          w_fire;

    dir_t          r_dir_q;
    logic          r_pend;
    dir_t          r_pend_dir;
    logic [1:0]    r_state;
    logic [TW-1:0] r_tcnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (bus.btn_up_raw),
        .o_stable (w_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (bus.btn_dn_raw),
        .o_stable (w_dn)
    );

    // both buttons together cancel out rather than picking a winner
    always_comb begin
        w_dir = DIR_NONE;
        if (w_up && !w_dn) begin
            w_dir = DIR_UP;
        end else if (w_dn && !w_up) begin
            w_dir = DIR_DOWN;
        end
    end

    assign w_press = (w_dir != DIR_NONE) && (w_dir != r_dir_q);
    assign w_tzero = (r_tcnt == '0);
    assign w_fire  = r_pend || (((r_state == ST_DELAY) || (r_state == ST_REPEAT)) && w_tzero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir_q    <= DIR_NONE;
            r_pend     <= 1'b0;
            r_pend_dir <= DIR_NONE;
            r_state    <= ST_IDLE;
            r_tcnt     <= '0;
        end else begin
            r_dir_q <= w_dir;
            if (w_press) begin
                r_pend     <= 1'b1;
                r_pend_dir <= w_dir;
                r_state    <= ST_DELAY;
                r_tcnt     <= T_DELAY;
            end else begin
                if (bus.tick) begin
                    if (r_pend) begin
                        r_pend <= 1'b0;
                        if (r_state == ST_DELAY) begin
                            r_tcnt <= r_tcnt - TW'(1);
                        end
                    end else begin
                        case (r_state)
                            ST_DELAY: begin
                                if (w_tzero) begin
                                    r_state <= ST_REPEAT;
                                    r_tcnt  <= T_PERIOD;
                                end else begin
                                    r_tcnt <= r_tcnt - TW'(1);
                                end
                            end
                            ST_REPEAT: begin
                                if (w_tzero) begin
                                    r_tcnt <= T_PERIOD;
                                end else begin
                                    r_tcnt <= r_tcnt - TW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // a pending tap survives the release so it still yields one step
                if (w_dir == DIR_NONE) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign bus.controls = (bus.tick && w_fire) ? dir_to_ctrl(r_pend ? r_pend_dir : r_dir_q) : 2'b00;
    assign bus.pressed  = {w_up, w_dn};

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Bench for paddle_input_ctrl: reference model of press timing and step schedule,
// checked every cycle, plus directed scenarios with hand-derived tick sequences.
module tb_paddle_input_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 3;
    localparam int RP  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    paddle_input_ctrl_if bus();

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ph;
    int nz_ctrl  = 0;
    int nz_press = 0;
    logic rst_seen = 1'b0;
    logic [1:0] tick_log [$];

    // model state
    logic       m_up, m_dn, m_pend, m_active;
    int         m_dirq, m_pdir, m_k;
    logic [0:7] h_up, h_dn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_tick(input string name, input int idx, input logic [1:0] exp);
        logic [1:0] act;
        act = (idx < tick_log.size()) ? tick_log[idx] : 2'bxx;
        check(name, {30'd0, act}, {30'd0, exp});
    endtask

    // a level is accepted once D consecutive synchronised samples disagree with it
    function automatic logic settled(input logic [0:7] h, input logic cur);
        for (int i = 2; i < 2 + DEB; i++) if (h[i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    // steps while held fall on tick 1, tick 1+RD, then every RP ticks
    function automatic logic sched(input int idx);
        if (idx == 1 + RD) return 1'b1;
        if (idx > 1 + RD && ((idx - 1 - RD) % RP) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] code(input int d);
        if (d == 1) return 2'b10;
        if (d == 2) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        logic [1:0] e;
        int d;
        e = 2'b00;
        if (bus.tick) begin
            if (m_pend) e = code(m_pdir);
            else if (m_active && sched(m_k + 1)) e = code(m_dirq);
        end
        if (rst_seen) begin
            check("pressed", {30'd0, bus.pressed}, {30'd0, m_up, m_dn});
            check("controls", {30'd0, bus.controls}, {30'd0, e});
            if (bus.controls != 2'b00) nz_ctrl++;
            if (bus.pressed != 2'b00) nz_press++;
            if (bus.tick) tick_log.push_back(bus.controls);
        end
        if (rst) begin
            m_up = 0; m_dn = 0; m_pend = 0; m_active = 0;
            m_dirq = 0; m_pdir = 0; m_k = 0;
            h_up = '0; h_dn = '0;
            rst_seen = 1'b1;
        end else begin
            d = (m_up && !m_dn) ? 1 : ((m_dn && !m_up) ? 2 : 0);
            if (d != 0 && d != m_dirq) begin
                m_pend = 1; m_pdir = d; m_active = 1; m_k = 0;
            end else begin
                if (bus.tick) begin
                    m_pend = 0;
                    if (m_active) m_k++;
                end
                if (d == 0) m_active = 0;
            end
            m_dirq = d;
            h_up = {bus.btn_up_raw, h_up[0:6]};
            h_dn = {bus.btn_dn_raw, h_dn[0:6]};
            if (settled(h_up, m_up)) m_up = !m_up;
            if (settled(h_dn, m_dn)) m_dn = !m_dn;
        end
    end

    initial begin
        ph = 0;
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 8;
            bus.tick = (ph == 7);
        end
    end

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 16 && ph != p; i++) clks(1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int ls, c0, p0;
        logic [1:0] exp2 [12];
        exp2 = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10,
                 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        rst = 1'b1;
        bus.btn_up_raw = 1'b0;
        bus.btn_dn_raw = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(2);
        check("reset_pressed", {30'd0, bus.pressed}, 32'd0);
        check("reset_controls", {30'd0, bus.controls}, 32'd0);

        // glitch shorter than the debounce window
        align(0);
        c0 = nz_ctrl; p0 = nz_press;
        bus.btn_up_raw = 1'b1;
        clks(3);
        bus.btn_up_raw = 1'b0;
        clks(16);
        check("glitch_controls", nz_ctrl - c0, 32'd0);
        check("glitch_pressed", nz_press - p0, 32'd0);

        // hold up: steps at ticks 1,4,6,8,10,12
        align(0);
        ls = tick_log.size();
        bus.btn_up_raw = 1'b1;
        clks(100);
        check("hold_pressed", {30'd0, bus.pressed}, 32'h2);
        for (int i = 0; i < 12; i++) check_tick("hold_tick", ls + i, exp2[i]);
        bus.btn_up_raw = 1'b0;
        clks(24);

        // both held cancels; dropping dn leaves a fresh up press
        align(0);
        c0 = nz_ctrl;
        bus.btn_up_raw = 1'b1;
        bus.btn_dn_raw = 1'b1;
        clks(40);
        check("both_pressed", {30'd0, bus.pressed}, 32'h3);
        check("both_controls", nz_ctrl - c0, 32'd0);
        align(0);
        ls = tick_log.size();
        bus.btn_dn_raw = 1'b0;
        clks(16);
        check_tick("both_release_t1", ls, 2'b10);
        check_tick("both_release_t2", ls + 1, 2'b00);
        bus.btn_up_raw = 1'b0;
        clks(24);

        // tap entirely between two ticks still gives one step
        align(2);
        ls = tick_log.size();
        bus.btn_up_raw = 1'b1;
        clks(4);
        bus.btn_up_raw = 1'b0;
        clks(40);
        check_tick("tap_t0", ls, 2'b00);
        check_tick("tap_t1", ls + 1, 2'b10);
        check_tick("tap_t2", ls + 2, 2'b00);
        check_tick("tap_t3", ls + 3, 2'b00);
        check("tap_pressed", {30'd0, bus.pressed}, 32'd0);

        // reversal from repeat: new direction at once, then after the delay
        align(0);
        bus.btn_up_raw = 1'b1;
        clks(48);
        ls = tick_log.size();
        bus.btn_up_raw = 1'b0;
        bus.btn_dn_raw = 1'b1;
        clks(40);
        check_tick("rev_t1", ls, 2'b01);
        check_tick("rev_t2", ls + 1, 2'b00);
        check_tick("rev_t3", ls + 2, 2'b00);
        check_tick("rev_t4", ls + 3, 2'b01);
        check_tick("rev_t5", ls + 4, 2'b00);

        // reset during repeat aborts everything
        align(0);
        rst = 1'b1;
        bus.btn_dn_raw = 1'b0;
        clks(1);
        rst = 1'b0;
        c0 = nz_ctrl; p0 = nz_press;
        clks(40);
        check("rst_mid_controls", nz_ctrl - c0, 32'd0);
        check("rst_mid_pressed", nz_press - p0, 32'd0);
        align(0);
        ls = tick_log.size();
        bus.btn_up_raw = 1'b1;
        clks(16);
        check_tick("after_rst_press", ls, 2'b10);
        bus.btn_up_raw = 1'b0;
        clks(16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
